bonus_hit_ctrl: RTL

Detects a player-shot hit on the bonus ship and converts it into a one-frame collision event, a score award and a timed explosion window. Sits directly downstream of the bonus-ship drawing stage: it consumes `bonus_ship_DR` and the player-fire drawing request, and returns `bonusFireCollision`, which the ship's motion controller uses to kill and respawn the ship. Its score output feeds the score counter; `explodeActive`/`hitX`/`hitY` feed the explosion/score-popup drawer.

---
 rtl/bonus_hit_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bonus_hit_ctrl.sv
// Bonus-ship hit controller: turns a ship/shot pixel overlap into a frame-aligned
// collision pulse, a score award and a timed explosion window.
module bonus_hit_ctrl #(
  parameter int EXPLODE_FRAMES = 30,
  parameter int SPECIAL_SHOT   = 14
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        standBy,
  input  logic        gameEnded,
  input  logic        bonus_ship_DR,
  input  logic        playerFire_DR,
  input  logic        shotFired,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        bonusFireCollision,
  output logic        scoreValid,
  output logic [8:0]  scoreAdd,
  output logic        explodeActive,
  output logic [10:0] hitX,
  output logic [10:0] hitY
);

  localparam int CNT_W = (EXPLODE_FRAMES < 2) ? 1 : $clog2(EXPLODE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, HIT_PENDING, EXPLODE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic [3:0]         shot_cnt, shot_cnt_nxt;
  logic               collision_nxt, score_valid_nxt, explode_nxt;
  logic [8:0]         score_nxt;
  logic [10:0]        hit_x_nxt, hit_y_nxt;
  logic               play_game, overlap;

  function automatic logic [8:0] score_for(input logic [3:0] idx);
    logic [8:0] pts;
    if (idx == 4'(SPECIAL_SHOT)) begin
      pts = 9'd300;
    end else begin
      case (idx[1:0])
        2'd0:    pts = 9'd50;
        2'd1:    pts = 9'd100;
        2'd2:    pts = 9'd150;
        default: pts = 9'd100;
      endcase
    end
    return pts;
  endfunction

  assign play_game = ~(standBy | gameEnded);
  assign overlap   = bonus_ship_DR & playerFire_DR;

  always_comb begin
    state_nxt       = state;
    frame_cnt_nxt   = frame_cnt;
    shot_cnt_nxt    = shot_cnt;
    collision_nxt   = 1'b0;
    score_valid_nxt = 1'b0;
    explode_nxt     = explodeActive;
    score_nxt       = scoreAdd;
    hit_x_nxt       = hitX;
    hit_y_nxt       = hitY;

    // Shot index runs 0..14 and wraps; the latch below sees the pre-increment value.
    if (standBy) begin
      shot_cnt_nxt = 4'd0;
    end else if (shotFired && state != IDLE) begin
      shot_cnt_nxt = (shot_cnt == 4'd14) ? 4'd0 : shot_cnt + 4'd1;
    end

    if (!play_game) begin
      state_nxt     = IDLE;
      frame_cnt_nxt = '0;
      explode_nxt   = 1'b0;
      score_nxt     = '0;
      hit_x_nxt     = '0;
      hit_y_nxt     = '0;
    end else begin
      case (state)
        IDLE: state_nxt = ARMED;
        ARMED: begin
          if (overlap) begin
            hit_x_nxt = pixelX;
            hit_y_nxt = pixelY;
            score_nxt = score_for(shot_cnt);
            state_nxt = HIT_PENDING;
          end
        end
        HIT_PENDING: begin
          if (startOfFrame) begin
            collision_nxt   = 1'b1;
            score_valid_nxt = 1'b1;
            explode_nxt     = 1'b1;
            frame_cnt_nxt   = CNT_W'(EXPLODE_FRAMES);
            state_nxt       = EXPLODE;
          end
        end
        EXPLODE: begin
          if (startOfFrame) begin
            if (frame_cnt <= CNT_W'(1)) begin
              frame_cnt_nxt = '0;
              explode_nxt   = 1'b0;
              state_nxt     = ARMED;
            end else begin
              frame_cnt_nxt = frame_cnt - CNT_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state              <= IDLE;
      frame_cnt          <= '0;
      shot_cnt           <= 4'd0;
      bonusFireCollision <= 1'b0;
      scoreValid         <= 1'b0;
      explodeActive      <= 1'b0;
      scoreAdd           <= '0;
      hitX               <= '0;
      hitY               <= '0;
    end else begin
      state              <= state_nxt;
      frame_cnt          <= frame_cnt_nxt;
      shot_cnt           <= shot_cnt_nxt;
      bonusFireCollision <= collision_nxt;
      scoreValid         <= score_valid_nxt;
      explodeActive      <= explode_nxt;
      scoreAdd           <= score_nxt;
      hitX               <= hit_x_nxt;
      hitY               <= hit_y_nxt;
    end
  end

endmodule
